// File: rtl/sram_ctrl_if.sv
// Request/response bus between a client and sram_ctrl.
// master drives requests and sees responses; slave is the controller.
interface sram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [18:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM access sequencer: one access per request, SETUP / ACCESS / HOLD strobing.
// Build macro SRAM_CTRL_BYTE_MASK_EN enables per-byte lane selects and masking of read data.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2  // ACCESS length in cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  bus,
  output logic [18:0] sram_adr,
  output logic [15:0] sram_dat_out,
  output logic        sram_dat_oe,
  input  logic [15:0] sram_dat_in,
  output logic        sram_cs_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
);

  // state  | meaning
  // IDLE   | ready for a request, all strobes inactive
  // SETUP  | address, lanes and chip select settle; write data starts driving
  // ACCESS | strobe (we_n or oe_n) active for WAIT_CYCLES cycles
  // HOLD   | strobes released, address/data held, completion pulse
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        lat_we;
  logic        we_sel;
  logic [1:0]  lanes_n;
  logic [15:0] rd_masked;

  logic        cs_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d, dat_oe_d;
  logic [18:0] adr_d;
  logic [15:0] dout_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // SETUP is only entered from IDLE, so its attributes come straight off the bus
  assign we_sel = (state == IDLE) ? bus.req_we : lat_we;

`ifdef SRAM_CTRL_BYTE_MASK_EN
  logic [1:0] lat_be;
  logic [1:0] be_sel;

  assign be_sel    = (state == IDLE) ? bus.req_be : lat_be;
  assign lanes_n   = ~be_sel;
  assign rd_masked = {lat_be[1] ? sram_dat_in[15:8] : 8'h00,
                      lat_be[0] ? sram_dat_in[7:0]  : 8'h00};

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_be <= 2'b00;
    end else if (bus.req_valid && state == IDLE) begin
      lat_be <= bus.req_be;
    end
  end
`else
  assign lanes_n   = 2'b00;
  assign rd_masked = sram_dat_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we <= 1'b0;
    end else if (bus.req_valid && state == IDLE) begin
      lat_we <= bus.req_we;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rsp_rdata_d = rsp_rdata_q;

    case (state)
      IDLE: begin
        if (bus.req_valid) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = ACCESS;
        cnt_nxt   = WAIT_LOAD;
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = HOLD;
          if (!lat_we) rsp_rdata_d = rd_masked;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Pin values are decoded from the state being entered so every pin is a flop output
  always_comb begin
    cs_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    dat_oe_d    = 1'b0;
    adr_d       = sram_adr;
    dout_d      = sram_dat_out;
    rsp_valid_d = 1'b0;

    case (state_nxt)
      SETUP: begin
        cs_n_d           = 1'b0;
        {ub_n_d, lb_n_d} = lanes_n;
        adr_d            = bus.req_addr;
        dout_d           = bus.req_wdata;
        dat_oe_d         = we_sel;
        oe_n_d           = we_sel;
      end
      ACCESS: begin
        cs_n_d           = 1'b0;
        {ub_n_d, lb_n_d} = lanes_n;
        dat_oe_d         = we_sel;
        we_n_d           = ~we_sel;
        oe_n_d           = we_sel;
      end
      HOLD: begin
        cs_n_d           = 1'b0;
        {ub_n_d, lb_n_d} = lanes_n;
        dat_oe_d         = we_sel;
        rsp_valid_d      = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      sram_cs_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_lb_n    <= 1'b1;
      sram_ub_n    <= 1'b1;
      sram_dat_oe  <= 1'b0;
      sram_adr     <= 19'd0;
      sram_dat_out <= 16'd0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 16'd0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sram_cs_n    <= cs_n_d;
      sram_oe_n    <= oe_n_d;
      sram_we_n    <= we_n_d;
      sram_lb_n    <= lb_n_d;
      sram_ub_n    <= ub_n_d;
      sram_dat_oe  <= dat_oe_d;
      sram_adr     <= adr_d;
      sram_dat_out <= dout_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: WAIT_CYCLES=2 instance with a behavioural SRAM,
// plus a WAIT_CYCLES=1 instance for back-to-back throughput.
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int viol  = 0;

  sram_ctrl_if b2();
  sram_ctrl_if b1();

  logic [18:0] adr2, adr1;
  logic [15:0] dout2, dout1, din2;
  logic [15:0] din1 = 16'h0F0F;
  logic        oe2en, cs2_n, oe2_n, we2_n, lb2_n, ub2_n;
  logic        oe1en, cs1_n, oe1_n, we1_n, lb1_n, ub1_n;

  sram_ctrl #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2),
    .sram_adr(adr2), .sram_dat_out(dout2), .sram_dat_oe(oe2en), .sram_dat_in(din2),
    .sram_cs_n(cs2_n), .sram_oe_n(oe2_n), .sram_we_n(we2_n),
    .sram_lb_n(lb2_n), .sram_ub_n(ub2_n)
  );

  sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .sram_adr(adr1), .sram_dat_out(dout1), .sram_dat_oe(oe1en), .sram_dat_in(din1),
    .sram_cs_n(cs1_n), .sram_oe_n(oe1_n), .sram_we_n(we1_n),
    .sram_lb_n(lb1_n), .sram_ub_n(ub1_n)
  );

  // Behavioural SRAM behind dut2, with an override for forcing read data
  logic [15:0] mem2 [256];
  logic        ovr_en  = 1'b0;
  logic [15:0] ovr_val = 16'h0000;
  assign din2 = ovr_en ? ovr_val : mem2[adr2[7:0]];

  always @(posedge clk) begin
    if (!cs2_n && !we2_n && oe2en) begin
      if (!lb2_n) mem2[adr2[7:0]][7:0]  <= dout2[7:0];
      if (!ub2_n) mem2[adr2[7:0]][15:8] <= dout2[15:8];
    end
  end

  always @(negedge clk) begin
    if ((!oe2_n && !we2_n) || (!we2_n && !oe2en) || (oe2en && !oe2_n) ||
        (!oe1_n && !we1_n) || (!we1_n && !oe1en) || (oe1en && !oe1_n))
      viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access on dut2; request fields are scrambled after the handshake
  task automatic do_req(input logic we, input logic [18:0] a, input logic [15:0] d,
                        input logic [1:0] be, output int lat, output int we_lo,
                        output int oe_cyc, output logic [15:0] rd);
    @(negedge clk);
    b2.req_valid = 1'b1;
    b2.req_we    = we;
    b2.req_addr  = a;
    b2.req_wdata = d;
    b2.req_be    = be;
    chk("ready_idle", b2.req_ready, 1);
    lat = 0; we_lo = 0; oe_cyc = 0; rd = 16'h0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        b2.req_valid = 1'b0;
        b2.req_we    = ~we;
        b2.req_addr  = 19'h7FFFF;
        b2.req_wdata = 16'h0000;
        b2.req_be    = ~be;
      end
      if (!we2_n) we_lo++;
      if (oe2en) oe_cyc++;
      if (b2.rsp_valid) begin
        lat = n;
        rd  = b2.rsp_rdata;
      end
    end
    chk("latency", lat, 4);
    @(negedge clk);
    chk("rsp_pulse", b2.rsp_valid, 0);
  endtask

  int lat, wl, oc, cnt;
  logic [15:0] rd;
  int hs_k [3];
  int nhs, rlow, nrsp;

  initial begin
    b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = '0; b2.req_wdata = '0; b2.req_be = '0;
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_wdata = '0; b1.req_be = '0;

    repeat (3) @(negedge clk);
    chk("rst_strobes", {cs2_n, oe2_n, we2_n, lb2_n, ub2_n, oe2en}, 6'b111110);
    chk("rst_adr", adr2, 0);
    chk("rst_dout", dout2, 0);
    chk("rst_rsp", {b2.rsp_valid, b2.rsp_rdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", b2.req_ready, 1);

    do_req(1'b1, 19'h00010, 16'hBEEF, 2'b11, lat, wl, oc, rd);
    chk("wr_we_cycles", wl, 2);
    chk("wr_oe_cycles", oc, 4);
    chk("wr_mem", mem2[8'h10], 16'hBEEF);

    do_req(1'b0, 19'h00010, 16'h0000, 2'b11, lat, wl, oc, rd);
    chk("rd_data", rd, 16'hBEEF);
    chk("rd_no_we_oe", {wl[3:0], oc[3:0]}, 0);

    do_req(1'b1, 19'h00020, 16'hFFFF, 2'b11, lat, wl, oc, rd);
    do_req(1'b1, 19'h00020, 16'h1234, 2'b01, lat, wl, oc, rd);
    do_req(1'b0, 19'h00020, 16'h0000, 2'b11, lat, wl, oc, rd);
`ifdef SRAM_CTRL_BYTE_MASK_EN
    chk("partial_write", rd, 16'hFF34);
`else
    chk("partial_write", rd, 16'h1234);
`endif

    ovr_en = 1'b1; ovr_val = 16'hA5C3;
    do_req(1'b0, 19'h00030, 16'h0000, 2'b10, lat, wl, oc, rd);
    ovr_en = 1'b0;
`ifdef SRAM_CTRL_BYTE_MASK_EN
    chk("masked_read", rd, 16'hA500);
`else
    chk("masked_read", rd, 16'hA5C3);
`endif

    do_req(1'b1, 19'h00040, 16'h5555, 2'b11, lat, wl, oc, rd);
    do_req(1'b1, 19'h00040, 16'hAAAA, 2'b00, lat, wl, oc, rd);
    chk("be00_we_cycles", wl, 2);
`ifdef SRAM_CTRL_BYTE_MASK_EN
    chk("be00_mem", mem2[8'h40], 16'h5555);
    chk("rdata_hold", b2.rsp_rdata, 16'hA500);
`else
    chk("be00_mem", mem2[8'h40], 16'hAAAA);
    chk("rdata_hold", b2.rsp_rdata, 16'hA5C3);
`endif

    // Abort a write in its first ACCESS cycle
    @(negedge clk);
    b2.req_valid = 1'b1; b2.req_we = 1'b1; b2.req_addr = 19'h00050;
    b2.req_wdata = 16'h1111; b2.req_be = 2'b11;
    @(negedge clk);
    b2.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_we_low", we2_n, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_strobes", {we2_n, cs2_n, oe2en, b2.rsp_valid}, 4'b1100);
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (b2.rsp_valid) cnt++;
    end
    chk("abort_no_rsp", cnt, 0);
    do_req(1'b0, 19'h00010, 16'h0000, 2'b11, lat, wl, oc, rd);
    chk("post_abort_rd", rd, 16'hBEEF);

    // Back-to-back reads on the WAIT_CYCLES=1 instance
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 19'h00003; b1.req_be = 2'b11;
    nhs = 0; rlow = 0; nrsp = 0;
    for (int k = 0; k < 20; k++) begin
      if (nhs < 3 && b1.req_ready) begin
        hs_k[nhs] = k;
        nhs++;
      end else if (nhs > 0 && nhs < 3 && !b1.req_ready) begin
        rlow++;
      end
      if (b1.rsp_valid) nrsp++;
      @(negedge clk);
      if (nhs == 3) b1.req_valid = 1'b0;
    end
    chk("b2b_hs", nhs, 3);
    chk("b2b_gap1", hs_k[1] - hs_k[0], 4);
    chk("b2b_gap2", hs_k[2] - hs_k[1], 4);
    chk("b2b_ready_low", rlow, 6);
    chk("b2b_rsp", nrsp, 3);
    chk("b2b_rdata", b1.rsp_rdata, 16'h0F0F);

    chk("strobe_rules", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: strobe-active cycles per access; legal range 1..15.
REQ-002 clk  input  1  system clock, 100 MHz.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  19  word address.
REQ-008 req_wdata  input  16  write data.
REQ-009 req_be  input  2  byte enables; bit0 = low byte, bit1 = high byte.
REQ-010 rsp_valid  output  1  one-cycle completion pulse, for reads and writes.
REQ-011 rsp_rdata  output  16  read data.
REQ-012 sram_adr  output  19  SRAM address (ADR).
REQ-013 sram_dat_out  output  16  data driven onto DAT.
REQ-014 sram_dat_oe  output  1  DAT tristate enable; top level drives DAT only when 1.
REQ-015 sram_dat_in  input  16  data sampled from DAT.
REQ-016 sram_cs_n, sram_oe_n, sram_we_n  output  1 each  active-low chip select, output enable and write enable (RAMCS, RAMOE, RAMWE).
REQ-017 sram_lb_n, sram_ub_n  output  1 each  active-low byte lane selects (RAMLB, RAMUB).

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS and HOLD; an unused encoding SHALL return to IDLE.
REQ-019 req_ready SHALL be 1 only in IDLE. A handshake occurs when req_valid and req_ready are both 1; the handshake latches we, addr, wdata and be, and moves the FSM to SETUP.
REQ-020 SETUP lasts 1 cycle: cs_n=0, lane selects = ~be, address driven; on a write, dat_oe=1 with we_n=1; on a read, oe_n=0.
REQ-021 ACCESS lasts exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter. On a write, we_n=0. On a read, oe_n stays 0 and sram_dat_in is captured on the final ACCESS cycle.
REQ-022 HOLD lasts 1 cycle: we_n=1 and oe_n=1; cs_n, address and dat_oe are held; rsp_valid=1. The FSM then returns to IDLE.
REQ-023 Latency: a handshake in cycle T gives rsp_valid in cycle T+2+WAIT_CYCLES; throughput is one access per WAIT_CYCLES+3 cycles.
REQ-024 Every SRAM-side output SHALL come directly from a flop; no combinational paths to the pins.
REQ-025 oe_n and we_n SHALL never be 0 in the same cycle; we_n=0 only while dat_oe=1; dat_oe=1 only for writes, from SETUP through HOLD.
REQ-026 rsp_rdata SHALL be updated only by reads; byte lanes not enabled read back as 0x00; the value holds until the next read completes.
REQ-027 A request with be=2'b00 SHALL still run the full cycle with both lane selects high; no data is written, and rsp_valid still pulses.
REQ-028 req_* inputs are ignored outside IDLE; changing them mid-access SHALL NOT affect the access in flight.

Reset
REQ-029 While rst=1, on the next clk edge: state=IDLE; cs_n, oe_n, we_n, lb_n and ub_n = 1; dat_oe=0; sram_adr=0; sram_dat_out=0; rsp_valid=0; rsp_rdata=0; counter=0.
REQ-030 After reset, req_ready SHALL be 1.
REQ-031 A reset in the middle of an access aborts it: strobes deassert at the next edge, no rsp_valid is issued, and the first request after rst falls is accepted normally.

Configuration
REQ-032 Macro SRAM_CTRL_BYTE_MASK_EN: when defined, req_be drives the lane selects and read masking as specified above. When undefined, req_be is ignored: lb_n and ub_n are 0 for every access and rsp_rdata returns all 16 bits. Handshake, timing and latency are identical in both builds.

Verification
REQ-033 Write, WAIT_CYCLES=2, addr=0x00010, data=0xBEEF, be=2'b11 -> we_n low for exactly 2 cycles; dat_oe covers SETUP..HOLD; rsp_valid in cycle T+4.
REQ-034 Read back addr=0x00010 with the SRAM model returning 0xBEEF -> rsp_rdata=0xBEEF with rsp_valid at T+4; oe_n and we_n never low together.
REQ-035 Write 0x1234 with be=2'b01 over stored 0xFFFF, then read with be=2'b11 -> memory holds 0xFF34 (macro defined) or 0x1234 (macro undefined).
REQ-036 Read with be=2'b10 while the SRAM model drives 0xA5C3 -> rsp_rdata=0xA500 (macro defined) or 0xA5C3 (macro undefined).
REQ-037 req_valid held high for 3 back-to-back requests, WAIT_CYCLES=1 -> handshakes spaced 4 cycles apart; req_ready low in SETUP, ACCESS and HOLD.
REQ-038 rst=1 asserted in the first ACCESS cycle of a write -> we_n=1, cs_n=1 and dat_oe=0 at the next edge; no rsp_valid; a following read completes normally.
